// File: rtl/fp_mul_sched.sv
// Two-requester round-robin scheduler sharing one combinational IEEE-754 multiplier.
// Round-to-nearest-even, gradual underflow, canonical quiet NaN on invalid results.

module fp_mul #(
    parameter int unsigned N_EXP = 11,
    parameter int unsigned N_MAN = 52
) (
    input  logic [N_EXP+N_MAN:0] i_a,
    input  logic [N_EXP+N_MAN:0] i_b,
    output logic [N_EXP+N_MAN:0] o_p,
    output logic [4:0]           o_flags
);
    localparam int unsigned SW   = N_MAN + 1;
    localparam int unsigned PW   = 2 * SW;
    localparam int unsigned PW1  = PW - 1;
    localparam int unsigned FW   = N_EXP + N_MAN;
    localparam int unsigned LZW  = $clog2(PW + 1);
    localparam int unsigned EW   = N_EXP + LZW + 2;
    localparam int unsigned BIAS = (1 << (N_EXP - 1)) - 1;
    localparam int unsigned EMAX = (1 << N_EXP) - 1;

    logic             w_sa, w_sb, w_sign;
    logic [N_EXP-1:0] w_ea, w_eb, w_eae, w_ebe, w_epre;
    logic [N_MAN-1:0] w_ma, w_mb, w_mant;
    logic             w_a_nan, w_a_inf, w_a_zero, w_b_nan, w_b_inf, w_b_zero;
    logic [SW-1:0]    w_siga, w_sigb;
    logic [PW-1:0]    w_prod, w_pn;
    logic [PW1-1:0]   w_ps;
    logic [LZW-1:0]   w_lz, w_sh;
    logic [EW-1:0]    w_be, w_shf;
    logic             w_tiny, w_big, w_lost, w_guard, w_sticky, w_rinc;
    logic             w_nan, w_inf, w_zero;
    logic [FW-1:0]    w_rnd;
    logic [FW:0]      w_p;

    assign {w_sa, w_ea, w_ma} = i_a;
    assign {w_sb, w_eb, w_mb} = i_b;

    assign w_a_nan  = (&w_ea) & (|w_ma);
    assign w_a_inf  = (&w_ea) & ~(|w_ma);
    assign w_a_zero = ~(|w_ea) & ~(|w_ma);
    assign w_b_nan  = (&w_eb) & (|w_mb);
    assign w_b_inf  = (&w_eb) & ~(|w_mb);
    assign w_b_zero = ~(|w_eb) & ~(|w_mb);

    // Subnormal operands carry no hidden bit but share exponent 1 with the smallest normals
    assign w_siga = {|w_ea, w_ma};
    assign w_sigb = {|w_eb, w_mb};
    assign w_eae  = (|w_ea) ? w_ea : N_EXP'(1);
    assign w_ebe  = (|w_eb) ? w_eb : N_EXP'(1);
    assign w_prod = PW'(w_siga) * PW'(w_sigb);

    always_comb begin
        w_lz = LZW'(PW);
        for (int i = 0; i < PW; i++) begin
            if (w_prod[i]) w_lz = LZW'(PW - 1 - i);
        end
    end

    // Biased exponent of the product once its leading one sits at the top bit
    assign w_be   = EW'(w_eae) + EW'(w_ebe) + EW'(1) - EW'(BIAS) - EW'(w_lz);
    assign w_pn   = w_prod << w_lz;
    assign w_tiny = w_be[EW-1] | (w_be == '0);
    assign w_big  = ~w_be[EW-1] & (w_be >= EW'(EMAX));
    assign w_shf  = EW'(1) - w_be;

    always_comb begin
        w_sh = LZW'(0);
        if (w_tiny) begin
            w_sh = (w_shf >= EW'(PW)) ? LZW'(PW) : LZW'(w_shf);
        end
    end

    // Denormalise tiny results, keeping every shifted-out bit in the sticky
    assign w_ps     = PW1'(w_pn >> w_sh);
    assign w_lost   = |(w_pn & ~({PW{1'b1}} << w_sh));
    assign w_mant   = w_ps[PW1-1 -: N_MAN];
    assign w_guard  = w_ps[N_MAN];
    assign w_sticky = (|w_ps[N_MAN-1:0]) | w_lost;
    assign w_epre   = w_tiny ? '0 : w_be[N_EXP-1:0];
    assign w_rinc   = w_guard & (w_sticky | w_mant[0]);
    // A carry out of the mantissa bumps the exponent: subnormal->normal or up to inf
    assign w_rnd    = {w_epre, w_mant} + FW'(w_rinc);

    assign w_nan  = w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_a_zero & w_b_inf);
    assign w_inf  = w_a_inf | w_b_inf;
    assign w_zero = w_a_zero | w_b_zero;
    assign w_sign = w_sa ^ w_sb;

    always_comb begin
        w_p = {w_sign, w_rnd};
        if (w_nan) begin
            w_p = {1'b0, {N_EXP{1'b1}}, 1'b1, {(N_MAN-1){1'b0}}};
        end else if (w_inf | w_big) begin
            w_p = {w_sign, {N_EXP{1'b1}}, {N_MAN{1'b0}}};
        end else if (w_zero) begin
            w_p = {w_sign, {FW{1'b0}}};
        end
    end

    always_comb begin
        o_flags = 5'b00001;
        if (&w_p[FW-1 -: N_EXP]) begin
            o_flags = (|w_p[N_MAN-1:0]) ? 5'b10000 : 5'b01000;
        end else if (~(|w_p[FW-1 -: N_EXP])) begin
            o_flags = (|w_p[N_MAN-1:0]) ? 5'b00010 : 5'b00100;
        end
    end

    assign o_p = w_p;
endmodule

module fp_mul_sched #(
    parameter int unsigned N_EXP = 11,
    parameter int unsigned N_MAN = 52
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in0_valid,
    input  logic                 in1_valid,
    output logic                 in0_ready,
    output logic                 in1_ready,
    input  logic [N_EXP+N_MAN:0] in0_a,
    input  logic [N_EXP+N_MAN:0] in0_b,
    input  logic [N_EXP+N_MAN:0] in1_a,
    input  logic [N_EXP+N_MAN:0] in1_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N_EXP+N_MAN:0] out_p,
    output logic                 out_id,
    output logic [4:0]           out_flags,
    output logic                 gnt_last,
    output logic [15:0]          nan_cnt
);
    localparam int unsigned W = N_EXP + N_MAN + 1;

    logic         r_out_valid, r_out_id, r_gnt_last;
    logic [W-1:0] r_out_p;
    logic [4:0]   r_out_flags;
    logic [15:0]  r_nan_cnt;

    logic         w_slot_free, w_gnt0, w_gnt1, w_xfer;
    logic [W-1:0] w_a, w_b, w_p;
    logic [4:0]   w_flags;

    // Round-robin: a lone requester always wins; under contention the other side goes next
    assign w_slot_free = ~r_out_valid | out_ready;
    assign w_gnt0      = in0_valid & (~in1_valid | r_gnt_last);
    assign w_gnt1      = in1_valid & (~in0_valid | ~r_gnt_last);
    assign in0_ready   = w_gnt0 & w_slot_free;
    assign in1_ready   = w_gnt1 & w_slot_free;
    assign w_xfer      = (w_gnt0 | w_gnt1) & w_slot_free;

    assign w_a = w_gnt1 ? in1_a : in0_a;
    assign w_b = w_gnt1 ? in1_b : in0_b;

    fp_mul #(.N_EXP(N_EXP), .N_MAN(N_MAN)) u_fp_mul (
        .i_a     (w_a),
        .i_b     (w_b),
        .o_p     (w_p),
        .o_flags (w_flags)
    );

    // Result register; a same-cycle transfer overwrites a drained result with no bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_p     <= '0;
            r_out_flags <= '0;
            r_out_id    <= 1'b0;
            r_gnt_last  <= 1'b1;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_p     <= w_p;
            r_out_flags <= w_flags;
            r_out_id    <= w_gnt1;
            r_gnt_last  <= w_gnt1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nan_cnt <= '0;
        end else if (w_xfer & w_flags[4] & ~(&r_nan_cnt)) begin
            r_nan_cnt <= r_nan_cnt + 16'd1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_p     = r_out_p;
    assign out_flags = r_out_flags;
    assign out_id    = r_out_id;
    assign gnt_last  = r_gnt_last;
    assign nan_cnt   = r_nan_cnt;
endmodule

// File: doc/fp_mul_sched.md
FP_MUL_SCHED -- requirements
Module: fp_mul_sched

Interface
REQ-001 Parameter N_EXP, default 11, exponent field width, passed to the multiplier datapath.
REQ-002 Parameter N_MAN, default 52, mantissa field width; W = N_EXP+N_MAN+1 is the operand and result width.
REQ-003 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, reset, asynchronous assert and active-low.
REQ-005 Ports in0_valid and in1_valid, input, 1 each, requester 0/1 has an operand pair.
REQ-006 Ports in0_ready and in1_ready, output, 1 each, requester 0/1 pair accepted this cycle.
REQ-007 Ports in0_a, in0_b, in1_a, in1_b, input, W each, IEEE-format operands per requester.
REQ-008 Port out_valid, output, 1, result register holds a valid product.
REQ-009 Port out_ready, input, 1, consumer accepts the result.
REQ-010 Port out_p, output, W, registered product.
REQ-011 Port out_id, output, 1, index of the requester that issued the product.
REQ-012 Port out_flags, output, 5, registered class {nan, inf, zero, dnorm, norm} from the multiplier.
REQ-013 Port gnt_last, output, 1, requester most recently granted (round-robin pointer).
REQ-014 Port nan_cnt, output, 16, saturating count of accepted products flagged nan.

Function
REQ-015 One combinational fp_mul datapath instance (N_EXP, N_MAN) shall be shared by both requesters; its operand inputs come from the granted requester.
REQ-016 slot_free = !out_valid | out_ready; no transfer is accepted when slot_free is 0.
REQ-017 Arbitration, round-robin: if only one inX_valid is set, grant X; if both are set, grant !gnt_last; if neither is set, make no grant.
REQ-018 inX_ready = grant_X & slot_free, combinational; ready is never asserted to a non-granted requester; ready does not depend on the requester's own valid except through arbitration.
REQ-019 Transfer is inX_valid & inX_ready; at most one transfer per cycle.
REQ-020 On transfer, the next edge loads out_p, out_flags and out_id = X, sets out_valid = 1, and sets gnt_last = X.
REQ-021 Latency: a pair accepted in cycle k appears on out_p with out_valid=1 in cycle k+1; throughput is one product per cycle while out_ready=1.
REQ-022 When out_valid & out_ready and there is no transfer in the same cycle, out_valid shall clear on the next edge.
REQ-023 When out_valid & out_ready and a transfer occurs in the same cycle, the new result replaces the old one with no bubble, and out_valid stays 1.
REQ-024 While out_valid=1 and out_ready=0, out_p, out_flags and out_id shall be held stable and both inX_ready shall be 0.
REQ-025 gnt_last changes only on transfer; an unaccepted grant does not move the pointer.
REQ-026 nan_cnt increments on each transfer whose datapath nan flag is 1 and saturates at 16'hFFFF (no wrap).
REQ-027 A requester may drop valid before it is accepted; the arbiter re-evaluates every cycle with no lockout.

Reset
REQ-028 While rst_n=0: out_valid=0, out_p=0, out_flags=0, out_id=0, gnt_last=1 (requester 0 wins first contention), nan_cnt=0.
REQ-029 Reset asserted mid-operation shall discard the held result immediately (asynchronously), without waiting for a clock edge.
REQ-030 The first transfer may occur on the first rising edge after rst_n deasserts.

Verification
REQ-031 in0 valid with a=64'h4000000000000000, b=64'h4008000000000000, out_ready=1 -> next cycle out_valid=1, out_p=64'h4018000000000000, out_flags=5'b00001, out_id=0.
REQ-032 Both requesters valid continuously after reset, out_ready=1 -> out_id sequence 0,1,0,1 on consecutive cycles, one product per cycle.
REQ-033 in1 valid with a=+inf (64'h7FF0000000000000), b=+0 -> out_flags=5'b10000, nan_cnt increments by 1; with nan_cnt preloaded to 16'hFFFF, the count stays 16'hFFFF.
REQ-034 out_ready=0 for 3 cycles with both requesters valid -> out_p and out_id stable, in0_ready=in1_ready=0, gnt_last unchanged; raising out_ready resumes with no lost or duplicated product.
REQ-035 rst_n pulsed low while out_valid=1 and in0 is mid-stream -> out_valid=0 without a clock edge; after release, the first contention grants requester 0.
